// File: rtl/motor_pwm_ctrl.sv
// Motor PWM controller: start/stop switch, inc/dec buttons, HOLD when both are held,
// period-aligned duty updates and a 7-segment readout of the commanded level.
module motor_pwm_ctrl #(
  parameter int LEVELS      = 9,
  parameter int STEP_CYCLES = 4,
  parameter int START_LEVEL = 5,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swt_start_stop,
  input  logic       swt_increase,
  input  logic       swt_decrease,
  output logic       motor_pwm,
  output logic       motor_running,
  output logic [3:0] duty_level,
  output logic [6:0] display
);

  localparam int PERIOD = LEVELS * STEP_CYCLES;

  typedef enum logic [1:0] {
    STANDBY = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  logic             start_m, start_s, inc_m, inc_s, dec_m, dec_s;
  logic             inc_d, dec_d;
  logic [3:0]       level, active_level;
  logic [CNT_W-1:0] pwm_cnt;
  logic [CNT_W:0]   thresh;
  logic             inc_evt, dec_evt, wrap, pwm_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_m <= 1'b0;
      start_s <= 1'b0;
      inc_m   <= 1'b0;
      inc_s   <= 1'b0;
      dec_m   <= 1'b0;
      dec_s   <= 1'b0;
      inc_d   <= 1'b0;
      dec_d   <= 1'b0;
    end else begin
      start_m <= swt_start_stop;
      start_s <= start_m;
      inc_m   <= swt_increase;
      inc_s   <= inc_m;
      dec_m   <= swt_decrease;
      dec_s   <= dec_m;
      inc_d   <= inc_s;
      dec_d   <= dec_s;
    end
  end

  assign inc_evt  = inc_s & ~inc_d;
  assign dec_evt  = dec_s & ~dec_d;
  assign wrap     = (pwm_cnt == CNT_W'(PERIOD - 1));
  assign thresh   = (CNT_W+1)'(active_level) * (CNT_W+1)'(STEP_CYCLES);
  assign pwm_next = (state == RUN) && ({1'b0, pwm_cnt} < thresh);

  // active_level only follows level at the wrap, so a period never changes duty mid-way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STANDBY;
      level         <= 4'd0;
      active_level  <= 4'd0;
      pwm_cnt       <= '0;
      motor_pwm     <= 1'b0;
      motor_running <= 1'b0;
    end else begin
      motor_pwm <= pwm_next;
      case (state)
        STANDBY: begin
          if (start_s) begin
            state         <= RUN;
            level         <= 4'(START_LEVEL);
            active_level  <= 4'(START_LEVEL);
            pwm_cnt       <= '0;
            motor_running <= 1'b1;
          end
        end
        RUN, HOLD: begin
          if (!start_s) begin
            state         <= STANDBY;
            level         <= 4'd0;
            active_level  <= 4'd0;
            pwm_cnt       <= '0;
            motor_running <= 1'b0;
          end else begin
            pwm_cnt <= wrap ? '0 : pwm_cnt + CNT_W'(1);
            if (wrap) active_level <= level;
            if (state == RUN) begin
              if (inc_s && dec_s) begin
                state <= HOLD;
              end else if (inc_evt && !dec_s) begin
                if (level < 4'(LEVELS)) level <= level + 4'd1;
              end else if (dec_evt && !inc_s) begin
                if (level != 4'd0) level <= level - 4'd1;
              end
            end else if (!(inc_s && dec_s)) begin
              state <= RUN;
            end
          end
        end
        default: begin
          state         <= STANDBY;
          motor_running <= 1'b0;
        end
      endcase
    end
  end

  assign duty_level = level;

  // Active-low segments, bit order gfedcba.
  always_comb begin
    display = 7'b0111111;
    case (duty_level)
      4'd0: display = 7'b1000000;
      4'd1: display = 7'b1111001;
      4'd2: display = 7'b0100100;
      4'd3: display = 7'b0110000;
      4'd4: display = 7'b0011001;
      4'd5: display = 7'b0010010;
      4'd6: display = 7'b0000010;
      4'd7: display = 7'b1111000;
      4'd8: display = 7'b0000000;
      4'd9: display = 7'b0010000;
      default: display = 7'b0111111;
    endcase
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Bench for motor_pwm_ctrl: directed stimulus pushes expected observations into a
// queue; a monitor samples the outputs and pops/compares them.
module tb_motor_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       swt_start_stop = 1'b0;
  logic       swt_increase = 1'b0;
  logic       swt_decrease = 1'b0;
  logic       motor_pwm;
  logic       motor_running;
  logic [3:0] duty_level;
  logic [6:0] display;

  motor_pwm_ctrl dut (
    .clk(clk),
    .rst(rst),
    .swt_start_stop(swt_start_stop),
    .swt_increase(swt_increase),
    .swt_decrease(swt_decrease),
    .motor_pwm(motor_pwm),
    .motor_running(motor_running),
    .duty_level(duty_level),
    .display(display)
  );

  // clock and reset
  always #5 clk = ~clk;

  // observation word: {hi_cnt[6:0], motor_pwm, motor_running, duty_level[3:0], display[6:0]}
  localparam int W = 20;
  localparam logic [W-1:0] M_CNT  = 20'hFE000;
  localparam logic [W-1:0] M_PWM  = 20'h01000;
  localparam logic [W-1:0] M_RUN  = 20'h00800;
  localparam logic [W-1:0] M_DUTY = 20'h00780;
  localparam logic [W-1:0] M_DISP = 20'h0007F;
  localparam logic [W-1:0] M_OUTS = M_PWM | M_RUN | M_DUTY | M_DISP;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        name_q[$];

  int total = 0;
  int bad = 0;
  int clr_req = 0;
  int clr_seen = 0;
  logic [6:0] hi_cnt = '0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // driver tasks
  task automatic push(input string nm, input int cnt, input bit pwm, input bit run,
                      input int duty, input logic [W-1:0] msk);
    logic [W-1:0] e;
    e = {7'(cnt), pwm, run, 4'(duty), seg(duty)};
    exp_q.push_back(e);
    msk_q.push_back(msk);
    name_q.push_back(nm);
  endtask

  task automatic press(input bit up);
    if (up) swt_increase = 1'b1;
    else swt_decrease = 1'b1;
    repeat (3) @(negedge clk);
    swt_increase = 1'b0;
    swt_decrease = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Counts motor_pwm high samples over 36 consecutive cycles.
  task automatic window(input string nm, input int exp_hi);
    clr_req++;
    repeat (35) @(negedge clk);
    push(nm, exp_hi, 1'b0, 1'b0, 0, M_CNT);
    @(negedge clk);
  endtask

  // scoreboard monitor
  always begin
    logic [W-1:0] obs, e, m;
    string nm;
    @(negedge clk);
    #1;
    if (clr_req != clr_seen) begin
      hi_cnt = 7'(motor_pwm);
      clr_seen = clr_req;
    end else begin
      hi_cnt = hi_cnt + 7'(motor_pwm);
    end
    obs = {hi_cnt, motor_pwm, motor_running, duty_level, display};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if ((obs & m) !== (e & m)) begin
        bad++;
        $display("FAIL %s: got=%05h expected=%05h (mask %05h)", nm, obs & m, e & m, m);
      end
    end
  end

  initial begin
    bit got;
    bit prev;
    repeat (2) @(negedge clk);
    push("reset_state", 0, 1'b0, 1'b0, 0, M_OUTS);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // start: RUN visible 3 edges after the switch changes
    swt_start_stop = 1'b1;
    repeat (2) @(negedge clk);
    push("start_not_yet", 0, 1'b0, 1'b0, 0, M_RUN | M_DUTY);
    @(negedge clk);
    push("start_run", 0, 1'b0, 1'b1, 5, M_RUN | M_DUTY | M_DISP);
    repeat (5) @(negedge clk);
    window("duty5_period", 20);

    // increase with saturation
    for (int i = 0; i < 6; i++) begin
      press(1'b1);
      push($sformatf("inc_%0d", i), 0, 1'b0, 1'b1, (6 + i > 9) ? 9 : 6 + i,
           M_RUN | M_DUTY | M_DISP);
    end
    repeat (40) @(negedge clk);
    window("duty9_period", 36);
    push("duty9_pwm_high", 0, 1'b1, 1'b1, 9, M_PWM | M_RUN);

    // stop then restart at the start level
    swt_start_stop = 1'b0;
    repeat (5) @(negedge clk);
    push("stop_outputs", 0, 1'b0, 1'b0, 0, M_OUTS);
    swt_start_stop = 1'b1;
    repeat (5) @(negedge clk);
    push("restart_level", 0, 1'b0, 1'b1, 5, M_RUN | M_DUTY | M_DISP);

    // decrease with saturation at 0
    for (int i = 0; i < 12; i++) begin
      press(1'b0);
      push($sformatf("dec_%0d", i), 0, 1'b0, 1'b1, (4 - i < 0) ? 0 : 4 - i,
           M_RUN | M_DUTY | M_DISP);
    end
    repeat (40) @(negedge clk);
    window("duty0_period", 0);
    push("duty0_running", 0, 1'b0, 1'b1, 0, M_PWM | M_RUN | M_DUTY);

    // hold
    press(1'b1);
    press(1'b1);
    swt_increase = 1'b1;
    swt_decrease = 1'b1;
    repeat (5) @(negedge clk);
    push("hold_outputs", 0, 1'b0, 1'b1, 2, M_OUTS);
    window("hold_period", 0);
    swt_increase = 1'b0;
    swt_decrease = 1'b0;
    repeat (5) @(negedge clk);
    push("hold_release", 0, 1'b0, 1'b1, 2, M_RUN | M_DUTY | M_DISP);
    repeat (40) @(negedge clk);
    window("duty2_period", 8);

    // mid-period change: rising pwm edge marks pwm_cnt=1 at this sample
    got = 1'b0;
    prev = motor_pwm;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (motor_pwm && !prev) got = 1'b1;
      prev = motor_pwm;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL pwm_edge_wait: got=no rising edge expected=edge within 100 cycles");
    end
    clr_req++;
    repeat (7) @(negedge clk);
    swt_increase = 1'b1;
    repeat (3) @(negedge clk);
    swt_increase = 1'b0;
    repeat (25) @(negedge clk);
    push("mid_old_duty", 8, 1'b0, 1'b0, 3, M_CNT | M_DUTY);
    @(negedge clk);
    window("mid_new_duty", 12);

    // stop during hold
    swt_increase = 1'b1;
    swt_decrease = 1'b1;
    repeat (5) @(negedge clk);
    swt_start_stop = 1'b0;
    repeat (5) @(negedge clk);
    push("stop_in_hold", 0, 1'b0, 1'b0, 0, M_OUTS);
    swt_increase = 1'b0;
    swt_decrease = 1'b0;

    // reset mid-period
    swt_start_stop = 1'b1;
    repeat (20) @(negedge clk);
    push("pre_reset_run", 0, 1'b0, 1'b1, 5, M_RUN | M_DUTY);
    @(negedge clk);
    rst = 1'b1;
    push("async_reset", 0, 1'b0, 1'b0, 0, M_OUTS);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push("post_reset_idle", 0, 1'b0, 1'b0, 0, M_RUN | M_DUTY);
    repeat (4) @(negedge clk);
    push("post_reset_restart", 0, 1'b0, 1'b1, 5, M_RUN | M_DUTY | M_DISP);

    // final report
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain: got=%0d pending expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
